// File: rtl/wbus_writeback_stage.sv
// ---------------------------------------------------------------------------
// wbus_writeback_stage
//   Registered W-bus select between execute and the register-file write port.
//   One of NUM_SRC result sources is chosen per instruction. The choice is
//   presented as a single write-back beat with valid/ready handshakes on both
//   sides. The MEM_SRC source is a load: its data comes from mem_rdata, and
//   the stage holds off upstream until mem_rvalid arrives.
//
//   Optional feature: define WBUS_TIMEOUT_EN to bound the load wait to
//   TIMEOUT cycles. An expired wait issues an error beat.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_sel, in_rd       source select and destination register
//   src_data            packed sources, source i at [i*BITS +: BITS]
//   mem_rdata/rvalid    load return data (1-cycle pulse)
//   wb_valid/wb_ready   downstream handshake
//   wb_data, wb_rd      write-back payload
//   wb_err              bad select or load timeout; data forced to 0
// ---------------------------------------------------------------------------
module wbus_writeback_stage #(
    parameter int BITS     = 16,
    parameter int NUM_SRC  = 4,
    parameter int SEL_BITS = 2,
    parameter int MEM_SRC  = 1,
    parameter int REG_BITS = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_BITS-1:0]     in_sel,
    input  logic [REG_BITS-1:0]     in_rd,
    input  logic [NUM_SRC*BITS-1:0] src_data,
    input  logic [BITS-1:0]         mem_rdata,
    input  logic                    mem_rvalid,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [BITS-1:0]         wb_data,
    output logic [REG_BITS-1:0]     wb_rd,
    output logic                    wb_err
);

    // Reject configurations the select/timeout logic cannot represent.
    if (NUM_SRC < 2 || (1 << SEL_BITS) < NUM_SRC || MEM_SRC >= NUM_SRC || TIMEOUT < 1) begin : g_param_check
        $error("wbus_writeback_stage: illegal parameter combination");
    end

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t              state;
    logic [REG_BITS-1:0] load_rd;
    logic [BITS-1:0]     sel_data;
    logic                sel_ok;
    logic                is_mem;
    logic                accept;
    logic                drain;

`ifdef WBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    // Source mux. Selects at or above NUM_SRC leave sel_ok low, which turns
    // the beat into an error beat.
    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (in_sel == SEL_BITS'(i)) begin
                sel_data = src_data[i*BITS +: BITS];
                sel_ok   = 1'b1;
            end
        end
    end

    assign is_mem = (in_sel == SEL_BITS'(MEM_SRC));
    assign drain  = wb_valid && wb_ready;
    // Masked during reset so that nothing upstream sees a handshake while the
    // stage is being cleared.
    assign in_ready = !reset && (state == IDLE) && (!wb_valid || wb_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            load_rd  <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_err   <= 1'b0;
`ifdef WBUS_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            // A drained beat frees the slot. A load in the same cycle below
            // overrides this, which gives back-to-back beats with no bubble.
            if (drain)
                wb_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mem) begin
                            load_rd <= in_rd;
                            state   <= WAIT_MEM;
`ifdef WBUS_TIMEOUT_EN
                            to_cnt  <= '0;
`endif
                        end else begin
                            wb_valid <= 1'b1;
                            wb_rd    <= in_rd;
                            wb_data  <= sel_ok ? sel_data : '0;
                            wb_err   <= !sel_ok;
                        end
                    end
                end
                WAIT_MEM: begin
                    // The output slot was free or draining when this state was
                    // entered, and nothing else loads it here, so the load
                    // result always has a free slot.
                    if (mem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= mem_rdata;
                        wb_rd    <= load_rd;
                        wb_err   <= 1'b0;
                        state    <= IDLE;
                    end
`ifdef WBUS_TIMEOUT_EN
                    // to_cnt counts the wait cycles already spent without data.
                    // The TIMEOUT-th empty cycle issues the error beat.
                    else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
                        wb_valid <= 1'b1;
                        wb_data  <= '0;
                        wb_rd    <= load_rd;
                        wb_err   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbus_writeback_stage.sv
// ---------------------------------------------------------------------------
// Testbench for wbus_writeback_stage (NUM_SRC=3, so in_sel=3 is a bad select).
// A transaction-level scoreboard holds the beats that are owed downstream.
// Accepted results push a beat, load completions push a beat, and handshakes
// pop a beat. Outputs are compared against the scoreboard head every cycle.
// Directed steps run first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_wbus_writeback_stage;

    localparam int BITS     = 16;
    localparam int NUM_SRC  = 3;
    localparam int SEL_BITS = 2;
    localparam int MEM_SRC  = 1;
    localparam int REG_BITS = 3;
    localparam int TIMEOUT  = 15;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_BITS-1:0]     in_sel;
    logic [REG_BITS-1:0]     in_rd;
    logic [NUM_SRC*BITS-1:0] src_data;
    logic [BITS-1:0]         mem_rdata;
    logic                    mem_rvalid;
    logic                    wb_valid;
    logic                    wb_ready;
    logic [BITS-1:0]         wb_data;
    logic [REG_BITS-1:0]     wb_rd;
    logic                    wb_err;

    wbus_writeback_stage #(
        .BITS(BITS), .NUM_SRC(NUM_SRC), .SEL_BITS(SEL_BITS),
        .MEM_SRC(MEM_SRC), .REG_BITS(REG_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rd(in_rd), .src_data(src_data),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BITS-1:0]     d;
        logic [REG_BITS-1:0] rd;
        logic                e;
    } beat_t;

    beat_t               q[$];     // beats owed downstream, head = current output
    bit                  lp;       // a load is outstanding
    logic [REG_BITS-1:0] prd;      // destination register of that load
`ifdef WBUS_TIMEOUT_EN
    int                  wc;       // empty wait cycles spent on that load
`endif
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [2:0] rd,
                         input logic [47:0] sd, input logic wr, input logic mv,
                         input logic [15:0] md);
        in_valid   = v;
        in_sel     = s;
        in_rd      = rd;
        src_data   = sd;
        wb_ready   = wr;
        mem_rvalid = mv;
        mem_rdata  = md;
    endtask

    // One clock: check in_ready for the driven inputs, advance the scoreboard
    // across the edge, then check the registered outputs.
    task automatic cyc();
        bit    exp_ready, hs, acc;
        beat_t b;
        int    s;
        #1;
        exp_ready = !reset && !lp && (q.size() == 0 || wb_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (reset) begin
            q.delete();
            lp = 0;
        end else begin
            hs  = (q.size() > 0) && wb_ready;
            acc = in_valid && exp_ready;
            if (hs) void'(q.pop_front());
            if (lp) begin
                if (mem_rvalid) begin
                    b.d = mem_rdata; b.rd = prd; b.e = 1'b0;
                    q.push_back(b);
                    lp = 0;
                end
`ifdef WBUS_TIMEOUT_EN
                else begin
                    wc++;
                    if (wc == TIMEOUT) begin
                        b.d = '0; b.rd = prd; b.e = 1'b1;
                        q.push_back(b);
                        lp = 0;
                    end
                end
`endif
            end
            if (acc) begin
                s = int'(in_sel);
                if (s == MEM_SRC) begin
                    lp  = 1;
                    prd = in_rd;
`ifdef WBUS_TIMEOUT_EN
                    wc  = 0;
`endif
                end else if (s < NUM_SRC) begin
                    b.d = src_data[s*BITS +: BITS]; b.rd = in_rd; b.e = 1'b0;
                    q.push_back(b);
                end else begin
                    b.d = '0; b.rd = in_rd; b.e = 1'b1;
                    q.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("wb_valid", 32'(wb_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("wb_data", 32'(wb_data), 32'(q[0].d));
            chk("wb_rd",   32'(wb_rd),   32'(q[0].rd));
            chk("wb_err",  32'(wb_err),  32'(q[0].e));
        end
    endtask

    initial begin
        lp  = 0;
        prd = '0;
        // Reset held two cycles with in_valid high.
        reset = 1'b1;
        drive(1, 0, 3, 48'h0000_0000_1234, 1, 0, 16'h0);
        repeat (2) begin
            cyc();
            chk("rst_wb_data", 32'(wb_data), 32'h0);
            chk("rst_wb_err",  32'(wb_err),  32'h0);
        end
        reset = 1'b0;

        // ALU pass-through.
        drive(1, 0, 3, 48'h0000_0000_1234, 1, 0, 16'h0);
        cyc();
        chk("alu_data", 32'(wb_data), 32'h1234);
        chk("alu_rd",   32'(wb_rd),   32'h3);

        // Back-to-back non-memory sources, one beat per cycle.
        drive(1, 2, 4, 48'hBEEF_0000_0000, 1, 0, 16'h0);
        cyc();
        chk("b2b_beef", 32'(wb_data), 32'hBEEF);
        drive(1, 0, 6, 48'h0000_0000_0040, 1, 0, 16'h0);
        cyc();
        chk("b2b_0040", 32'(wb_data), 32'h0040);
        drive(0, 0, 0, 48'h0, 1, 0, 16'h0);
        cyc();

        // Load: mem_rvalid in the accept cycle is not a hit; data 3 cycles later.
        drive(1, 1, 5, 48'h0, 1, 1, 16'hFFFF);
        cyc();
        drive(1, 0, 7, 48'h0000_0000_3333, 1, 0, 16'h0);
        repeat (2) cyc();
        drive(0, 0, 0, 48'h0, 1, 1, 16'hA5A5);
        cyc();
        chk("load_data", 32'(wb_data), 32'hA5A5);
        chk("load_rd",   32'(wb_rd),   32'h5);
        drive(0, 0, 0, 48'h0, 1, 0, 16'h0);
        cyc();

        // Backpressure: beat held for 4 stalled cycles, then a pending input
        // follows with no bubble.
        drive(1, 0, 2, 48'h0000_0000_0007, 1, 0, 16'h0);
        cyc();
        drive(1, 2, 1, 48'h1111_0000_0000, 0, 0, 16'h0);
        repeat (4) begin
            cyc();
            chk("bp_hold", 32'(wb_data), 32'h0007);
        end
        wb_ready = 1'b1;
        cyc();
        chk("bp_next_valid", 32'(wb_valid), 32'h1);
        chk("bp_next_data",  32'(wb_data),  32'h1111);
        drive(0, 0, 0, 48'h0, 1, 0, 16'h0);
        cyc();

        // Bad select: in_sel=3 with NUM_SRC=3.
        drive(1, 3, 7, 48'hFFFF_FFFF_FFFF, 1, 0, 16'h0);
        cyc();
        chk("bad_err",  32'(wb_err),  32'h1);
        chk("bad_data", 32'(wb_data), 32'h0);
        drive(0, 0, 0, 48'h0, 1, 0, 16'h0);
        cyc();

`ifdef WBUS_TIMEOUT_EN
        // Load with no data: error beat after TIMEOUT cycles.
        drive(1, 1, 6, 48'h0, 1, 0, 16'h0);
        cyc();
        in_valid = 1'b0;
        repeat (TIMEOUT) cyc();
        chk("to_valid", 32'(wb_valid), 32'h1);
        chk("to_err",   32'(wb_err),   32'h1);
        chk("to_rd",    32'(wb_rd),    32'h6);
        cyc();
`endif

        // Reset mid-WAIT_MEM, then a late mem_rvalid must be ignored.
        drive(1, 1, 2, 48'h0, 1, 0, 16'h0);
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(0, 0, 0, 48'h0, 1, 1, 16'hDEAD);
        cyc();
        chk("late_rvalid", 32'(wb_valid), 32'h0);
        mem_rvalid = 1'b0;
        cyc();

        // Randomized traffic against the scoreboard.
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 63) == 0);
            in_valid   = $urandom_range(0, 1);
            in_sel     = 2'($urandom_range(0, 3));
            in_rd      = 3'($urandom);
            src_data   = {16'($urandom), 16'($urandom), 16'($urandom)};
            wb_ready   = ($urandom_range(0, 9) < 7);
            mem_rvalid = ($urandom_range(0, 9) < 3);
            mem_rdata  = 16'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
